// File: rtl/aq_ifu_ibuf_queue.sv
// Instruction buffer queue for the fetch unit.
// Circular buffer of DEPTH half-word entries. Up to CRT_NUM entries are
// created and up to RET_NUM entries are retired per cycle. Head slots
// are read straight from storage, so there is no write-to-read bypass.
module aq_ifu_ibuf_queue #(
  parameter int DEPTH   = 16,
  parameter int CRT_NUM = 3,
  parameter int RET_NUM = 2,
  parameter int HINFO_W = 22,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic                         forever_cpuclk,
  input  logic                         cpurst_b,
  input  logic                         ibuf_flush_en,
  input  logic [CRT_NUM-1:0]           ibuf_create_vld,
  input  logic [16*CRT_NUM-1:0]        ibuf_create_inst,
  input  logic [2*CRT_NUM-1:0]         ibuf_create_pred_taken,
  input  logic [HINFO_W*CRT_NUM-1:0]   ibuf_create_halt_info,
  input  logic [CRT_NUM-1:0]           ibuf_create_acc_err,
  input  logic [CRT_NUM-1:0]           ibuf_create_pgflt,
  output logic                         ibuf_create_rdy,
  input  logic [RET_NUM-1:0]           ibuf_retire_en,
  output logic [RET_NUM-1:0]           ibuf_head_vld,
  output logic [16*RET_NUM-1:0]        ibuf_head_inst,
  output logic [2*RET_NUM-1:0]         ibuf_head_pred_taken,
  output logic [HINFO_W*RET_NUM-1:0]   ibuf_head_halt_info,
  output logic [RET_NUM-1:0]           ibuf_head_acc_err,
  output logic [RET_NUM-1:0]           ibuf_head_pgflt,
  output logic [CNT_W-1:0]             ibuf_entry_cnt
);

  // pointers and occupancy
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_cnt;

  // entry storage
  logic [DEPTH-1:0][15:0]         r_inst;
  logic [DEPTH-1:0][1:0]          r_pt;
  logic [DEPTH-1:0][HINFO_W-1:0]  r_hinfo;
  logic [DEPTH-1:0]               r_acc;
  logic [DEPTH-1:0]               r_pgf;

  // per-entry write enables and write data
  logic [DEPTH-1:0]               w_we;
  logic [DEPTH-1:0][15:0]         w_inst;
  logic [DEPTH-1:0][1:0]          w_pt;
  logic [DEPTH-1:0][HINFO_W-1:0]  w_hinfo;
  logic [DEPTH-1:0]               w_acc;
  logic [DEPTH-1:0]               w_pgf;

  logic                           w_rdy;
  logic [CNT_W-1:0]               w_crt_cnt;
  logic [CNT_W-1:0]               w_ret_cnt;
  logic [RET_NUM-1:0][PTR_W-1:0]  w_hidx;

  // ready only from registered occupancy; same-cycle retire never raises it
  assign w_rdy = ({1'b0, r_cnt} + (CNT_W+1)'(CRT_NUM)) <= (CNT_W+1)'(DEPTH);
  assign ibuf_create_rdy = w_rdy;
  assign ibuf_entry_cnt  = r_cnt;

  // create count: run of ones from bit 0; all-or-nothing when not ready
  always_comb begin : crt_count
    logic run;
    run       = 1'b1;
    w_crt_cnt = '0;
    for (int k = 0; k < CRT_NUM; k++) begin
      if (run && ibuf_create_vld[k]) w_crt_cnt = w_crt_cnt + CNT_W'(1);
      else                           run       = 1'b0;
    end
    if (!w_rdy || ibuf_flush_en) w_crt_cnt = '0;
  end

  // retire count: run of ones from bit 0, clipped to occupancy
  always_comb begin : ret_count
    logic run;
    run       = 1'b1;
    w_ret_cnt = '0;
    for (int k = 0; k < RET_NUM; k++) begin
      if (run && ibuf_retire_en[k]) w_ret_cnt = w_ret_cnt + CNT_W'(1);
      else                          run       = 1'b0;
    end
    if (w_ret_cnt > r_cnt) w_ret_cnt = r_cnt;
  end

  // route each accepted create port to entry (wptr+k) mod DEPTH
  always_comb begin
    w_we    = '0;
    w_inst  = '0;
    w_pt    = '0;
    w_hinfo = '0;
    w_acc   = '0;
    w_pgf   = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int k = 0; k < CRT_NUM; k++) begin
        if ((CNT_W'(k) < w_crt_cnt) && ((r_wptr + PTR_W'(k)) == PTR_W'(e))) begin
          w_we[e]    = 1'b1;
          w_inst[e]  = ibuf_create_inst[16*k +: 16];
          w_pt[e]    = ibuf_create_pred_taken[2*k +: 2];
          w_hinfo[e] = ibuf_create_halt_info[HINFO_W*k +: HINFO_W];
          w_acc[e]   = ibuf_create_acc_err[k];
          w_pgf[e]   = ibuf_create_pgflt[k];
        end
      end
    end
  end

  // pointer/occupancy update; flush wins over create and retire
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (ibuf_flush_en) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      r_wptr <= r_wptr + PTR_W'(w_crt_cnt);
      r_rptr <= r_rptr + PTR_W'(w_ret_cnt);
      r_cnt  <= r_cnt + w_crt_cnt - w_ret_cnt;
    end
  end

  // resettable entry fields, each entry enabled only by its own write enable
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_pt    <= '0;
      r_hinfo <= '0;
      r_acc   <= '0;
      r_pgf   <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_we[e]) begin
          r_pt[e]    <= w_pt[e];
          r_hinfo[e] <= w_hinfo[e];
          r_acc[e]   <= w_acc[e];
          r_pgf[e]   <= w_pgf[e];
        end
      end
    end
  end

  // instruction storage is not reset; a flop is only written when targeted
  always_ff @(posedge forever_cpuclk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (w_we[e]) r_inst[e] <= w_inst[e];
    end
  end

  // head slots read combinationally at (rptr+i) mod DEPTH
  for (genvar i = 0; i < RET_NUM; i++) begin : g_head
    assign w_hidx[i]                                 = r_rptr + PTR_W'(i);
    assign ibuf_head_vld[i]                          = r_cnt > CNT_W'(i);
    assign ibuf_head_inst[16*i +: 16]                = r_inst[w_hidx[i]];
    assign ibuf_head_pred_taken[2*i +: 2]            = r_pt[w_hidx[i]];
    assign ibuf_head_halt_info[HINFO_W*i +: HINFO_W] = r_hinfo[w_hidx[i]];
    assign ibuf_head_acc_err[i]                      = r_acc[w_hidx[i]];
    assign ibuf_head_pgflt[i]                        = r_pgf[w_hidx[i]];
  end

endmodule

// File: tb/tb_aq_ifu_ibuf_queue.sv
// Randomized + directed bench for aq_ifu_ibuf_queue against a queue model.
module tb_aq_ifu_ibuf_queue;
  localparam int DEPTH = 16, CRT = 3, RET = 2, HW = 22, CW = 5;

  logic              clk, rst_n, flush;
  logic [CRT-1:0]    cvld, cacc, cpgf;
  logic [16*CRT-1:0] cinst;
  logic [2*CRT-1:0]  cpt;
  logic [HW*CRT-1:0] chi;
  logic              rdy;
  logic [RET-1:0]    ret, hvld, hacc, hpgf;
  logic [16*RET-1:0] hinst;
  logic [2*RET-1:0]  hpt;
  logic [HW*RET-1:0] hhi;
  logic [CW-1:0]     cnt;

  aq_ifu_ibuf_queue #(.DEPTH(DEPTH), .CRT_NUM(CRT), .RET_NUM(RET), .HINFO_W(HW)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .ibuf_flush_en(flush),
    .ibuf_create_vld(cvld), .ibuf_create_inst(cinst), .ibuf_create_pred_taken(cpt),
    .ibuf_create_halt_info(chi), .ibuf_create_acc_err(cacc), .ibuf_create_pgflt(cpgf),
    .ibuf_create_rdy(rdy), .ibuf_retire_en(ret), .ibuf_head_vld(hvld),
    .ibuf_head_inst(hinst), .ibuf_head_pred_taken(hpt), .ibuf_head_halt_info(hhi),
    .ibuf_head_acc_err(hacc), .ibuf_head_pgflt(hpgf), .ibuf_entry_cnt(cnt));

  typedef struct packed {
    logic [15:0]   inst;
    logic [1:0]    pt;
    logic [HW-1:0] hi;
    logic          acc;
    logic          pgf;
  } ent_t;

  ent_t q[$];
  int checks = 0, errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // compare every observable output against the model queue
  task automatic cmp_model();
    chk("cnt", 64'(cnt), 64'(q.size()));
    chk("rdy", 64'(rdy), 64'((DEPTH - q.size()) >= CRT));
    for (int i = 0; i < RET; i++) begin
      chk("head_vld", 64'(hvld[i]), 64'(q.size() > i));
      if (q.size() > i) begin
        chk("head_inst", 64'(hinst[16*i +: 16]), 64'(q[i].inst));
        chk("head_pt",   64'(hpt[2*i +: 2]),     64'(q[i].pt));
        chk("head_hi",   64'(hhi[HW*i +: HW]),   64'(q[i].hi));
        chk("head_acc",  64'(hacc[i]),           64'(q[i].acc));
        chk("head_pgf",  64'(hpgf[i]),           64'(q[i].pgf));
      end
    end
  endtask

  // one clock: drive inputs, advance model by the spec rules, compare
  task automatic cycle(logic [CRT-1:0] cv, logic [RET-1:0] re, logic fl, logic [16*CRT-1:0] ins);
    ent_t nq[$];
    int c, r;
    cvld = cv; ret = re; flush = fl; cinst = ins;
    cpt = CRT*2'($urandom); chi = {$urandom, $urandom, $urandom};
    cacc = CRT'($urandom); cpgf = CRT'($urandom);
    c = 0;
    for (int k = 0; k < CRT; k++) begin if (!cv[k]) break; c++; end
    if (DEPTH - q.size() < CRT) c = 0;
    r = 0;
    for (int k = 0; k < RET; k++) begin if (!re[k]) break; r++; end
    if (r > q.size()) r = q.size();
    nq = q;
    if (fl) nq.delete();
    else begin
      for (int k = 0; k < r; k++) void'(nq.pop_front());
      for (int k = 0; k < c; k++)
        nq.push_back('{inst: ins[16*k +: 16], pt: cpt[2*k +: 2], hi: chi[HW*k +: HW],
                       acc: cacc[k], pgf: cpgf[k]});
    end
    @(posedge clk); #1;
    q = nq;
    cmp_model();
  endtask

  function automatic logic [16*CRT-1:0] rinst();
    return {16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  initial begin
    rst_n = 1'b0; flush = 0; cvld = 0; ret = 0; cinst = 0; cpt = 0; chi = 0; cacc = 0; cpgf = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 64'(cnt), 0);
    chk("rst_rdy", 64'(rdy), 1);
    chk("rst_vld", 64'(hvld), 0);
    rst_n = 1'b1;

    // three creates land in order
    cycle(3'b111, 2'b00, 0, {16'h3333, 16'h2222, 16'h1111});
    chk("d37_cnt", 64'(cnt), 3);
    chk("d37_vld", 64'(hvld), 2'b11);
    chk("d37_inst", 64'(hinst), 32'h2222_1111);
    cycle(3'b000, 2'b00, 1, rinst());

    // gap in create_vld stops the run
    cycle(3'b101, 2'b00, 0, {16'h7777, 16'h6666, 16'hAAAA});
    chk("d38_cnt", 64'(cnt), 1);
    chk("d38_vld", 64'(hvld), 2'b01);
    chk("d38_inst", 64'(hinst[15:0]), 16'hAAAA);
    cycle(3'b000, 2'b00, 1, rinst());

    // near-full: no partial accept, ready from registered count
    repeat (4) cycle(3'b111, 2'b00, 0, rinst());
    cycle(3'b011, 2'b00, 0, rinst());
    chk("d39_cnt14", 64'(cnt), 14);
    chk("d39_rdy0", 64'(rdy), 0);
    cycle(3'b111, 2'b11, 0, rinst());
    chk("d39_cnt12", 64'(cnt), 12);
    chk("d39_rdy1", 64'(rdy), 1);
    cycle(3'b000, 2'b00, 1, rinst());

    // retire clipped to occupancy
    cycle(3'b001, 2'b00, 0, rinst());
    cycle(3'b000, 2'b11, 0, rinst());
    chk("d40_cnt", 64'(cnt), 0);
    chk("d40_vld", 64'(hvld), 0);

    // move both pointers to 15, then create across the wrap
    cycle(3'b000, 2'b00, 1, rinst());
    repeat (5) cycle(3'b111, 2'b00, 0, rinst());
    repeat (7) cycle(3'b000, 2'b11, 0, rinst());
    cycle(3'b000, 2'b01, 0, rinst());
    chk("d41_cnt0", 64'(cnt), 0);
    cycle(3'b111, 2'b00, 0, {16'hC003, 16'hB002, 16'hA001});
    chk("d41_head", 64'(hinst), 32'hB002_A001);
    cycle(3'b000, 2'b01, 0, rinst());
    chk("d41_head2", 64'(hinst), 32'hC003_B002);

    // flush beats create and retire
    cycle(3'b111, 2'b01, 1, rinst());
    chk("d42_cnt", 64'(cnt), 0);
    chk("d42_rdy", 64'(rdy), 1);
    chk("d42_vld", 64'(hvld), 0);
    cycle(3'b001, 2'b00, 0, {16'h0, 16'h0, 16'h5A5A});
    chk("d42_inst", 64'(hinst[15:0]), 16'h5A5A);

    // random traffic
    for (int n = 0; n < 1500; n++)
      cycle(CRT'($urandom), RET'($urandom), ($urandom_range(0, 49) == 0), rinst());

    // asynchronous reset mid-operation
    cvld = 3'b111; ret = 2'b01; flush = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", 64'(cnt), 0);
    chk("arst_vld", 64'(hvld), 0);
    chk("arst_rdy", 64'(rdy), 1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmp_model();

    for (int n = 0; n < 1000; n++)
      cycle(CRT'($urandom), RET'($urandom), ($urandom_range(0, 49) == 0), rinst());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
